pcs_scrambler: RTL and testbench

//   10GBASE-R PCS scrambler, x^58 + x^39 + 1, processing DATA_WIDTH bits per valid beat.

---
 rtl/pcs_scrambler_if.sv | 24 ++
 rtl/pcs_scrambler.sv | 69 ++++++
 tb/tb_pcs_scrambler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/pcs_scrambler_if.sv
// Payload stream between the 64b/66b encoder, the scrambler and the gearbox.
// Names follow the scrambler's view: i_* flow into it, o_* flow out of it.
interface pcs_scrambler_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  i_data_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  o_data_valid;
  logic [DATA_WIDTH-1:0] o_data;

  modport master (
    output i_data_valid,
    output i_data,
    input  o_data_valid,
    input  o_data
  );

  modport slave (
    input  i_data_valid,
    input  i_data,
    output o_data_valid,
    output o_data
  );
endinterface

// File: rtl/pcs_scrambler.sv
// 10GBASE-R payload scrambler, x^58 + x^39 + 1, DATA_WIDTH bits per valid beat, 1-cycle latency.
// Build macro SCRAMBLER_SELF_SYNC_EN selects the self-synchronous Clause 49 form; default is additive.
module pcs_scrambler #(
  parameter int DATA_WIDTH       = 32,
  parameter bit SCRAMBLER_BYPASS = 1'b0
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  pcs_scrambler_if.slave         if_s
);

  localparam logic [57:0] SEED = {58{1'b1}};

  generate
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
      $error("pcs_scrambler: DATA_WIDTH must be 32 or 64");
    end
  endgenerate

  logic [57:0]           r_lfsr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  logic [57:0]           w_lfsr_nxt;
  logic [DATA_WIDTH-1:0] w_scr;

  // Serial recurrence unrolled across the beat; bit 0 is the first bit on the line.
  always_comb begin
    logic [57:0] v_s;
    logic        v_o;
    v_s   = r_lfsr;
    w_scr = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
`ifdef SCRAMBLER_SELF_SYNC_EN
      v_o      = if_s.i_data[i] ^ v_s[38] ^ v_s[57];
      w_scr[i] = v_o;
      v_s      = {v_s[56:0], v_o};
`else
      v_o      = if_s.i_data[i] ^ v_s[57];
      w_scr[i] = v_o;
      v_s      = {v_s[56:0], v_s[57] ^ v_s[38]};
`endif
    end
    w_lfsr_nxt = v_s;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_lfsr  <= SEED;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= if_s.i_data_valid;
      if (if_s.i_data_valid) begin
        if (SCRAMBLER_BYPASS) begin
          r_data <= if_s.i_data;
          r_lfsr <= SEED;
        end else begin
          r_data <= w_scr;
          r_lfsr <= w_lfsr_nxt;
        end
      end
    end
  end

  assign if_s.o_data       = r_data;
  assign if_s.o_data_valid = r_valid;

endmodule

// File: tb/tb_pcs_scrambler.sv
// Bench for pcs_scrambler (DATA_WIDTH=32): directed vectors plus random beats against a
// sequence-recurrence model of the x^58 + x^39 + 1 scrambler.
module tb_pcs_scrambler;

  logic i_clk;
  logic i_reset_n;

  pcs_scrambler_if #(.DATA_WIDTH(32)) u_if ();
  pcs_scrambler_if #(.DATA_WIDTH(32)) u_bif ();

  pcs_scrambler #(.DATA_WIDTH(32), .SCRAMBLER_BYPASS(1'b0)) u_dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .if_s      (u_if.slave)
  );

  pcs_scrambler #(.DATA_WIDTH(32), .SCRAMBLER_BYPASS(1'b1)) u_byp (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .if_s      (u_bif.slave)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_err    = 0;

  // hist[0] is the bit inserted 58 steps ago, hist[19] the one inserted 39 steps ago.
  bit          q_hist[$];
  logic        exp_valid;
  logic [31:0] exp_data;

  function automatic void model_reset();
    q_hist.delete();
    for (int i = 0; i < 58; i++) q_hist.push_back(1'b1);
  endfunction

  function automatic logic [31:0] model_beat(logic [31:0] d);
    logic [31:0] o;
    bit          x;
    for (int i = 0; i < 32; i++) begin
`ifdef SCRAMBLER_SELF_SYNC_EN
      o[i] = d[i] ^ q_hist[0] ^ q_hist[19];
      x    = o[i];
`else
      o[i] = d[i] ^ q_hist[0];
      x    = q_hist[0] ^ q_hist[19];
`endif
      q_hist.push_back(x);
      void'(q_hist.pop_front());
    end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check what the previous step produced, then drive this step's inputs.
  task automatic step(input string tag, input logic v, input logic [31:0] d);
    @(negedge i_clk);
    chk({tag, "_valid"}, {31'b0, u_if.o_data_valid}, {31'b0, exp_valid});
    chk({tag, "_data"}, u_if.o_data, exp_data);
    u_if.i_data_valid = v;
    u_if.i_data       = d;
    exp_valid         = v;
    if (v) exp_data = model_beat(d);
  endtask

  task automatic do_reset(input string tag);
    @(negedge i_clk);
    i_reset_n         = 1'b0;
    u_if.i_data_valid = 1'b0;
    u_if.i_data       = '0;
    #1;
    chk({tag, "_rst_valid"}, {31'b0, u_if.o_data_valid}, 32'd0);
    chk({tag, "_rst_data"}, u_if.o_data, 32'd0);
    @(negedge i_clk);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;
  endtask

  initial begin
    i_reset_n          = 1'b0;
    u_if.i_data_valid  = 1'b0;
    u_if.i_data        = '0;
    u_bif.i_data_valid = 1'b0;
    u_bif.i_data       = '0;
    model_reset();
    exp_valid = 1'b0;
    exp_data  = '0;

    do_reset("r0");
    step("z1", 1'b1, 32'h0);
    step("z2", 1'b1, 32'h0);
    step("z3", 1'b0, 32'h0);
`ifndef SCRAMBLER_SELF_SYNC_EN
    chk("z_lit2", u_if.o_data, 32'h03FF_FFFF);
`endif

    do_reset("r1");
    step("ones", 1'b1, 32'hFFFF_FFFF);
    step("ones_out", 1'b0, 32'h0);
`ifndef SCRAMBLER_SELF_SYNC_EN
    chk("ones_lit", u_if.o_data, 32'h0000_0000);
`endif

    do_reset("r2");
    step("gap_b0", 1'b1, 32'h0);
    step("gap_o0", 1'b0, 32'h1234_5678);
`ifndef SCRAMBLER_SELF_SYNC_EN
    chk("gap_lit0", u_if.o_data, 32'hFFFF_FFFF);
`endif
    for (int i = 0; i < 4; i++) step("gap_idle", 1'b0, 32'hA5A5_A5A5);
    step("gap_b1", 1'b1, 32'h0);
    step("gap_o1", 1'b0, 32'h0);
`ifndef SCRAMBLER_SELF_SYNC_EN
    chk("gap_lit1", u_if.o_data, 32'h03FF_FFFF);
`endif

    do_reset("r3");
    step("mid_b0", 1'b1, 32'h1111_1111);
    step("mid_b1", 1'b1, 32'h2222_2222);
    step("mid_b2", 1'b1, 32'h3333_3333);
    do_reset("mid");
    step("mid_after", 1'b1, 32'h0);
    step("mid_out", 1'b0, 32'h0);
`ifndef SCRAMBLER_SELF_SYNC_EN
    chk("mid_lit", u_if.o_data, 32'hFFFF_FFFF);
`endif

    @(negedge i_clk);
    u_bif.i_data_valid = 1'b1;
    u_bif.i_data       = 32'hDEAD_BEEF;
    @(negedge i_clk);
    u_bif.i_data_valid = 1'b0;
    u_bif.i_data       = 32'h0;
    chk("byp_valid", {31'b0, u_bif.o_data_valid}, 32'd1);
    chk("byp_data", u_bif.o_data, 32'hDEAD_BEEF);
    @(negedge i_clk);
    chk("byp_hold_valid", {31'b0, u_bif.o_data_valid}, 32'd0);
    chk("byp_hold_data", u_bif.o_data, 32'hDEAD_BEEF);

    do_reset("r4");
    for (int n = 0; n < 10; n++) begin
      step("rnd", 1'b1, $urandom);
      if ($urandom_range(0, 1) == 1) step("rnd_idle", 1'b0, $urandom);
    end
    step("rnd_last", 1'b0, 32'h0);
    step("rnd_end", 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
